if_prefetch_queue: RTL and testbench

IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

---
 rtl/sys_defs.sv | 22 ++
 rtl/if_prefetch_queue.sv | 120 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_defs.sv
// Shared processor definitions: bus command encodings, memory tag width, XLEN.
// Also holds the prefetch entry record used by the fetch front end.
package sys_defs;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic             alloc;
    logic             filled;
  } pq_entry_t;

endpackage

// File: rtl/if_prefetch_queue.sv
// In-order instruction prefetch queue: issues tagged loads, matches out-of-order returns,
// releases words in program order; redirect flushes and marks in-flight tags stale.
module if_prefetch_queue
  import sys_defs::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [XLEN-1:0]   proc2Imem_addr,
  output bus_cmd_e          proc2Imem_command,
  input  logic [TAG_W-1:0]  Imem2proc_response,
  input  logic [XLEN-1:0]   Imem2proc_data,
  input  logic [TAG_W-1:0]  Imem2proc_tag,
  output logic              inst_valid,
  output logic [XLEN-1:0]   inst,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  pq_entry_t        ent_q [DEPTH];
  pq_entry_t        ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [15:1]      stale_q, stale_d;

  logic             issue, pop, ret_hit, stale_hit;
  logic [PTR_W-1:0] ret_idx;

  // Gating uses the registered count only, so a pop never frees a slot for the same cycle.
  assign proc2Imem_command = (!rst && !redirect && (count_q < CNT_W'(DEPTH))) ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = fetch_pc_q;
  assign inst_valid        = !rst && !redirect && ent_q[head_q].alloc && ent_q[head_q].filled;
  assign inst              = rst ? '0 : ent_q[head_q].data;
  assign inst_pc           = rst ? '0 : ent_q[head_q].pc;

  always_comb begin
    ent_d      = ent_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    stale_d    = stale_q;
    ret_hit    = 1'b0;
    ret_idx    = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if ((Imem2proc_tag != '0) && ent_q[i].alloc && !ent_q[i].filled &&
          (ent_q[i].tag == Imem2proc_tag)) begin
        ret_hit = 1'b1;
        ret_idx = PTR_W'(i);
      end
    end

    stale_hit = (Imem2proc_tag != '0) && !ret_hit && stale_q[Imem2proc_tag];
    issue     = (proc2Imem_command == BUS_LOAD) && (Imem2proc_response != '0);
    pop       = inst_valid && inst_ready;

    if (stale_hit) stale_d[Imem2proc_tag] = 1'b0;

    if (redirect) begin
      // A tag returning in the redirect cycle is already home and must not be marked stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].alloc && !ent_q[i].filled && !(ret_hit && (ret_idx == PTR_W'(i))))
          stale_d[ent_q[i].tag] = 1'b1;
        ent_d[i].alloc  = 1'b0;
        ent_d[i].filled = 1'b0;
      end
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (ret_hit) begin
        ent_d[ret_idx].data   = Imem2proc_data;
        ent_d[ret_idx].filled = 1'b1;
      end
      if (pop) begin
        ent_d[head_q].alloc  = 1'b0;
        ent_d[head_q].filled = 1'b0;
        head_d               = head_q + PTR_W'(1);
      end
      if (issue) begin
        ent_d[tail_q].alloc  = 1'b1;
        ent_d[tail_q].filled = 1'b0;
        ent_d[tail_q].tag    = Imem2proc_response;
        ent_d[tail_q].pc     = fetch_pc_q;
        tail_d               = tail_q + PTR_W'(1);
        fetch_pc_d           = fetch_pc_q + XLEN'(4);
      end
      count_d = count_q + CNT_W'(issue) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
      stale_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      stale_q    <= stale_d;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: a tagged memory model feeds a program-order scoreboard of {pc, word}.
module tb_if_prefetch_queue;
  import sys_defs::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] proc2Imem_addr;
  bus_cmd_e    proc2Imem_command;
  logic [3:0]  Imem2proc_response = '0;
  logic [31:0] Imem2proc_data = '0;
  logic [3:0]  Imem2proc_tag = '0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .proc2Imem_addr(proc2Imem_addr), .proc2Imem_command(proc2Imem_command),
    .Imem2proc_response(Imem2proc_response), .Imem2proc_data(Imem2proc_data),
    .Imem2proc_tag(Imem2proc_tag), .inst_valid(inst_valid), .inst(inst),
    .inst_pc(inst_pc), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { int due; logic [3:0] tag; logic [31:0] data; } ret_t;

  exp_t sb[$];
  ret_t rq[$];
  int   pop_cyc[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, grant_left = 0, pops = 0;
  int   ret_delay = 3;
  bit   auto_ret = 1'b0;
  logic [3:0]  next_tag = 4'd1, man_tag = 4'd0;
  logic        obs_valid;
  bus_cmd_e    obs_cmd;
  logic [31:0] obs_addr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // One clock: starts and ends at a falling edge; the caller has already set inst_ready/redirect.
  task automatic cycle();
    exp_t e;
    Imem2proc_tag      = '0;
    Imem2proc_data     = '0;
    Imem2proc_response = '0;
    if (man_tag != 4'd0) begin
      for (int i = 0; i < rq.size(); i++) begin
        if (rq[i].tag == man_tag) begin
          Imem2proc_tag  = rq[i].tag;
          Imem2proc_data = rq[i].data;
          rq.delete(i);
          break;
        end
      end
      man_tag = 4'd0;
    end else if (auto_ret && rq.size() > 0 && rq[0].due <= cyc) begin
      Imem2proc_tag  = rq[0].tag;
      Imem2proc_data = rq[0].data;
      void'(rq.pop_front());
    end
    #1;
    obs_valid = inst_valid;
    obs_cmd   = proc2Imem_command;
    obs_addr  = proc2Imem_addr;
    if (proc2Imem_command == BUS_LOAD && grant_left > 0) begin
      Imem2proc_response = next_tag;
      grant_left--;
      sb.push_back('{proc2Imem_addr, data_of(proc2Imem_addr)});
      rq.push_back('{cyc + ret_delay, next_tag, data_of(proc2Imem_addr)});
      next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
    end
    if (inst_valid && inst_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst", inst, e.data);
      end
      pops++;
      pop_cyc.push_back(cyc);
    end
    if (redirect) sb.delete();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && pops < n; i++) cycle();
    check("pop_count", pops, n);
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic do_reset(input bit keep_rets);
    rst = 1'b1; redirect = 1'b0; inst_ready = 1'b0; man_tag = '0; grant_left = 0;
    Imem2proc_tag = '0; Imem2proc_response = '0; Imem2proc_data = '0;
    @(negedge clk);
    #1;
    check("rst_cmd", proc2Imem_command, BUS_NONE);
    check("rst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_addr", proc2Imem_addr, RST_PC);
    sb.delete();
    if (!keep_rets) rq.delete();
    pop_cyc.delete();
    next_tag = 4'd1; pops = 0; cyc = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Steady stream: tags 1..4, 3-cycle return, output one per cycle.
    do_reset(1'b0);
    auto_ret = 1'b1; inst_ready = 1'b1; grant_left = 4;
    wait_pops(4, 40);
    check("first_latency", pop_cyc[0], 4);
    check("back_to_back", pop_cyc[3], 7);

    // Out-of-order returns hold the head until tag 1 arrives.
    do_reset(1'b0);
    auto_ret = 1'b0; inst_ready = 1'b1; grant_left = 3;
    repeat (3) cycle();
    man_tag = 4'd3; cycle();
    cycle();
    check("ooo_wait_t3", obs_valid, 1'b0);
    man_tag = 4'd1; cycle();
    check("ooo_wait_t1", obs_valid, 1'b0);
    man_tag = 4'd2; cycle();
    check("ooo_head", obs_valid, 1'b1);
    wait_pops(3, 20);

    // Full queue stalls issue; a pop frees a slot only from the next cycle.
    do_reset(1'b0);
    auto_ret = 1'b1; inst_ready = 1'b0; grant_left = 5;
    repeat (4) cycle();
    cycle();
    check("full_cmd", obs_cmd, BUS_NONE);
    repeat (4) cycle();
    check("full_hold", obs_cmd, BUS_NONE);
    check("full_valid", obs_valid, 1'b1);
    inst_ready = 1'b1; cycle();
    check("pop_no_issue", obs_cmd, BUS_NONE);
    inst_ready = 1'b0; cycle();
    check("resume_cmd", obs_cmd, BUS_LOAD);
    check("resume_addr", obs_addr, 32'h10);
    inst_ready = 1'b1;
    wait_pops(5, 30);

    // Redirect with tags 5,6 in flight; late returns dropped and stale bits cleared.
    do_reset(1'b0);
    next_tag = 4'd5; auto_ret = 1'b0; inst_ready = 1'b1; grant_left = 2;
    repeat (2) cycle();
    redirect = 1'b1; redirect_pc = 32'h200; cycle();
    check("redir_cmd", obs_cmd, BUS_NONE);
    redirect = 1'b0;
    check("stale5_set", dut.stale_q[5], 1'b1);
    check("stale6_set", dut.stale_q[6], 1'b1);
    grant_left = 1; next_tag = 4'd7; cycle();
    check("redir_addr", obs_addr, 32'h200);
    check("redir_cmd_load", obs_cmd, BUS_LOAD);
    man_tag = 4'd5; cycle();
    man_tag = 4'd6; cycle();
    check("stale_drop5", obs_valid, 1'b0);
    cycle();
    check("stale_drop6", obs_valid, 1'b0);
    check("stale_clear", 32'(dut.stale_q), 32'h0);
    man_tag = 4'd7; cycle();
    wait_pops(1, 10);

    // Refused grants hold the fetch address and queue occupancy.
    do_reset(1'b0);
    auto_ret = 1'b1; inst_ready = 1'b1; grant_left = 0;
    redirect = 1'b1; redirect_pc = 32'h40; cycle();
    redirect = 1'b0;
    repeat (3) begin
      cycle();
      check("refuse_addr", obs_addr, 32'h40);
      check("refuse_cmd", obs_cmd, BUS_LOAD);
      check("refuse_cnt", 32'(dut.count_q), 32'h0);
    end
    grant_left = 1; cycle();
    check("grant_addr", obs_addr, 32'h40);
    cycle();
    check("post_grant_addr", obs_addr, 32'h44);
    wait_pops(1, 10);

    // Reset with filled entries; a pre-reset tag returning afterwards is ignored.
    do_reset(1'b0);
    auto_ret = 1'b1; inst_ready = 1'b0; grant_left = 3;
    repeat (8) cycle();
    check("pre_rst_valid", obs_valid, 1'b1);
    auto_ret = 1'b0; grant_left = 1; cycle();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", inst_valid, 1'b0);
    check("mid_rst_cmd", proc2Imem_command, BUS_NONE);
    do_reset(1'b1);
    next_tag = 4'd5; auto_ret = 1'b0; inst_ready = 1'b1; grant_left = 1;
    cycle();
    check("restart_addr", obs_addr, RST_PC);
    check("restart_cmd", obs_cmd, BUS_LOAD);
    man_tag = 4'd4; cycle();
    cycle();
    check("orphan_drop", obs_valid, 1'b0);
    man_tag = 4'd5; cycle();
    wait_pops(1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
